// File: rtl/puf_pkg.sv
// puf_pkg: shared FSM states and challenge/mode constants for the RO-PUF verifier.
package puf_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, NEXT, FINISH} state_e;
  localparam logic [7:0] LFSR_TAPS     = 8'hB8;
  localparam logic [7:0] ZERO_SEED_SUB = 8'h01;
  localparam logic       MODE_ENROLL   = 1'b0;
  localparam logic       MODE_VERIFY   = 1'b1;
endpackage

// File: rtl/puf_chal_lfsr.sv
// puf_chal_lfsr: 8-bit Fibonacci LFSR challenge generator; a zero seed is replaced so the register never locks up.
module puf_chal_lfsr
  import puf_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       adv,
  input  logic [7:0] seed,
  output logic [7:0] chal
);
  logic [7:0] chal_q, chal_d;
  always_comb begin
    chal_d = chal_q;
    if (load) chal_d = (seed == 8'h00) ? ZERO_SEED_SUB : seed;
    else if (adv) chal_d = {chal_q[6:0], ^(chal_q & LFSR_TAPS)};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) chal_q <= '0;
    else chal_q <= chal_d;
  assign chal = chal_q;
endmodule

// File: rtl/puf_verifier.sv
// puf_verifier: issues LFSR challenges to the PUF array, enrolls a reference response set
// and verifies later runs by accumulated Hamming distance against a threshold.
module puf_verifier
  import puf_pkg::*;
#(
  parameter int N_CHAL      = 4,
  parameter int RESP_W      = 8,
  parameter int TIMEOUT_CYC = 1023,
  parameter int HD_W        = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic              mode,
  input  logic [7:0]        seed,
  input  logic [HD_W-1:0]   threshold,
  output logic [7:0]        puf_challenge,
  output logic              puf_clear,
  input  logic [RESP_W-1:0] puf_response,
  input  logic [RESP_W-1:0] puf_finish,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              error,
  output logic [HD_W-1:0]   hd,
  output logic              enrolled
);
  localparam int IDX_W = $clog2(N_CHAL);
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam int PC_W  = $clog2(RESP_W + 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HD_W-1:0]   hd_q, hd_d;
  logic              mode_q, mode_d, pass_q, pass_d, err_q, err_d, enr_q, enr_d;
  logic              ref_we, lfsr_load, lfsr_adv;
  logic [RESP_W-1:0] ref_mem_q [N_CHAL];
  logic [HD_W:0]     hd_sum;

  function automatic logic [PC_W-1:0] popcount(input logic [RESP_W-1:0] v);
    popcount = '0;
    for (int i = 0; i < RESP_W; i++) popcount += PC_W'(v[i]);
  endfunction

  assign hd_sum = {1'b0, hd_q} + (HD_W+1)'(popcount(puf_response ^ ref_mem_q[idx_q]));

  puf_chal_lfsr u_lfsr (
    .clk  (clk),
    .rst_n(rst_n),
    .load (lfsr_load),
    .adv  (lfsr_adv),
    .seed (seed),
    .chal (puf_challenge)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    hd_d      = hd_q;
    pass_d    = pass_q;
    err_d     = err_q;
    enr_d     = enr_q;
    ref_we    = 1'b0;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    if (ena) begin
      case (state_q)
        IDLE: if (start) begin
          mode_d    = mode;
          hd_d      = '0;
          pass_d    = 1'b0;
          err_d     = 1'b0;
          idx_d     = '0;
          lfsr_load = 1'b1;
          if (mode == MODE_VERIFY && !enr_q) begin
            err_d   = 1'b1;
            state_d = FINISH;
          end else begin
            if (mode == MODE_ENROLL) enr_d = 1'b0;
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          cnt_d   = '0;
          state_d = WAIT;
        end
        // First WAIT cycle still sees the finish flags from the previous measurement.
        WAIT: if (cnt_q != '0 && &puf_finish) state_d = CAPTURE;
          else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
            err_d   = 1'b1;
            state_d = FINISH;
          end else cnt_d = cnt_q + CNT_W'(1);
        CAPTURE: begin
          if (mode_q == MODE_ENROLL) ref_we = 1'b1;
          else hd_d = hd_sum[HD_W] ? '1 : hd_sum[HD_W-1:0];
          state_d = NEXT;
        end
        NEXT: if (idx_q == IDX_W'(N_CHAL - 1)) state_d = FINISH;
          else begin
            idx_d    = idx_q + IDX_W'(1);
            lfsr_adv = 1'b1;
            state_d  = ISSUE;
          end
        FINISH: begin
          if (!err_q && mode_q == MODE_ENROLL) enr_d = 1'b1;
          if (!err_q && mode_q == MODE_VERIFY) pass_d = hd_q <= threshold;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      mode_q  <= 1'b0;
      hd_q    <= '0;
      pass_q  <= 1'b0;
      err_q   <= 1'b0;
      enr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      hd_q    <= hd_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      enr_q   <= enr_d;
    end

  always_ff @(posedge clk)
    if (ref_we) ref_mem_q[idx_q] <= puf_response;

  assign puf_clear = ena && state_q == ISSUE;
  assign done      = ena && state_q == FINISH;
  assign busy      = state_q != IDLE;
  assign pass      = pass_q;
  assign error     = err_q;
  assign hd        = hd_q;
  assign enrolled  = enr_q;
endmodule
